// File: rtl/alu_bist_checker.sv
// alu_bist_checker
// ----------------
// Built-in self-test sequencer for the 6-bit logic unit. Each vector is driven
// onto a_o/b_o/fxn_o, held for SETTLE idle cycles and then checked against an
// internal golden model. The run reports pass/fail, a saturating mismatch
// count and the first failing vector.
//
// Build option:
//   ALU_BIST_EXHAUSTIVE_EN  defined   -> full sweep, fxn/A/B each 0..max
//                                        (32768 vectors)
//                           undefined -> 9-pair directed set per function
//                                        (72 vectors)
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle pulse, starts a run when idle or done
//   a_o, b_o, fxn_o    vector driven into the unit under test
//   out_i, c_i, v_i    unit response (OUT, Cled, Vled), sampled in CHECK only
//   busy               run in progress
//   done               high from run end until the next accepted start
//   pass               valid with done, 1 when no vector mismatched
//   err_count          mismatching vectors, saturates at 65535
//   fail_fxn/a/b/out   first failing vector and the OUT it produced

module alu_bist_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [5:0]  a_o,
    output logic [5:0]  b_o,
    output logic [2:0]  fxn_o,
    input  logic [5:0]  out_i,
    input  logic        c_i,
    input  logic        v_i,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [2:0]  fail_fxn,
    output logic [5:0]  fail_a,
    output logic [5:0]  fail_b,
    output logic [5:0]  fail_out
);

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StWait,
        StCheck,
        StDone
    } state_e;

    // WAIT counts down from SETTLE-1 to 0, giving SETTLE cycles in WAIT.
    localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

    state_e      r_state;
    logic [5:0]  r_a;
    logic [5:0]  r_b;
    logic [2:0]  r_fxn;
    logic [7:0]  r_wait;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [15:0] r_err_count;
    logic [2:0]  r_fail_fxn;
    logic [5:0]  r_fail_a;
    logic [5:0]  r_fail_b;
    logic [5:0]  r_fail_out;

    // ------------------------------------------------------------------
    // Golden model of the unit, evaluated on the vector currently driven.
    // ------------------------------------------------------------------
    logic [5:0] w_add_x;
    logic [5:0] w_add_y;
    logic       w_add_cin;
    logic [6:0] w_sum;
    logic       w_sum_v;
    logic [5:0] w_exp_out;
    logic       w_exp_c;
    logic       w_exp_v;
    logic       w_mismatch;

    // Negation and subtraction share the adder as x + ~y + 1.
    always_comb begin
        w_add_x   = r_a;
        w_add_y   = r_b;
        w_add_cin = 1'b0;
        case (r_fxn)
            3'b010: begin
                w_add_x   = 6'd0;
                w_add_y   = ~r_a;
                w_add_cin = 1'b1;
            end
            3'b011: begin
                w_add_x   = 6'd0;
                w_add_y   = ~r_b;
                w_add_cin = 1'b1;
            end
            3'b111: begin
                w_add_x   = r_a;
                w_add_y   = ~r_b;
                w_add_cin = 1'b1;
            end
            default: begin
                w_add_x   = r_a;
                w_add_y   = r_b;
                w_add_cin = 1'b0;
            end
        endcase
    end

    assign w_sum   = {1'b0, w_add_x} + {1'b0, w_add_y} + {6'd0, w_add_cin};
    // Signed overflow: operands agree in sign, result does not.
    assign w_sum_v = (w_add_x[5] == w_add_y[5]) && (w_sum[5] != w_add_x[5]);

    always_comb begin
        w_exp_out = 6'd0;
        w_exp_c   = 1'b0;
        w_exp_v   = 1'b0;
        case (r_fxn)
            3'b000: w_exp_out = r_a;
            3'b001: w_exp_out = r_b;
            3'b100: w_exp_out = {5'd0, ($signed(r_a) < $signed(r_b))};
            3'b101: w_exp_out = ~(r_a ^ r_b);
            default: begin
                w_exp_out = w_sum[5:0];
                w_exp_c   = w_sum[6];
                w_exp_v   = w_sum_v;
            end
        endcase
    end

    assign w_mismatch = (out_i != w_exp_out) || (c_i != w_exp_c) || (v_i != w_exp_v);

    // ------------------------------------------------------------------
    // Vector sequencing
    // ------------------------------------------------------------------
    logic       w_load_first;
    logic       w_load_next;
    logic       w_last_vec;
    logic [5:0] w_first_a;
    logic [5:0] w_first_b;
    logic [5:0] w_next_a;
    logic [5:0] w_next_b;
    logic [2:0] w_next_fxn;

    assign w_load_first = ((r_state == StIdle) || (r_state == StDone)) && start;
    assign w_load_next  = (r_state == StCheck) && !w_last_vec;

`ifdef ALU_BIST_EXHAUSTIVE_EN
    // The driven vector itself is the sweep counter: fxn outer, A middle, B inner.
    assign w_first_a  = 6'd0;
    assign w_first_b  = 6'd0;
    assign w_last_vec = (r_fxn == 3'b111) && (r_a == 6'h3F) && (r_b == 6'h3F);
    assign {w_next_fxn, w_next_a, w_next_b} = {r_fxn, r_a, r_b} + 15'd1;
`else
    localparam logic [3:0] LastIdx = 4'd8;

    logic [3:0] r_idx;
    logic [3:0] w_next_idx;

    function automatic logic [11:0] f_pair(input logic [3:0] idx);
        logic [11:0] pair;
        case (idx)
            4'd0:    pair = {6'b001100, 6'b000001};
            4'd1:    pair = {6'b000000, 6'b000000};
            4'd2:    pair = {6'b000001, 6'b000001};
            4'd3:    pair = {6'b100000, 6'b100000};
            4'd4:    pair = {6'b101010, 6'b101010};
            4'd5:    pair = {6'b101111, 6'b101010};
            4'd6:    pair = {6'b101111, 6'b111111};
            4'd7:    pair = {6'b101000, 6'b101010};
            4'd8:    pair = {6'b101010, 6'b111111};
            default: pair = 12'd0;
        endcase
        return pair;
    endfunction

    assign {w_first_a, w_first_b} = f_pair(4'd0);
    assign w_next_idx = (r_idx == LastIdx) ? 4'd0 : r_idx + 4'd1;
    assign w_next_fxn = (r_idx == LastIdx) ? r_fxn + 3'd1 : r_fxn;
    assign {w_next_a, w_next_b} = f_pair(w_next_idx);
    assign w_last_vec = (r_fxn == 3'b111) && (r_idx == LastIdx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 4'd0;
        end else if (w_load_first) begin
            r_idx <= 4'd0;
        end else if (w_load_next) begin
            r_idx <= w_next_idx;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    logic [15:0] w_err_next;

    // Saturating increment; only used when the current vector mismatches.
    assign w_err_next = (r_err_count == 16'hFFFF) ? r_err_count : r_err_count + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_a         <= 6'd0;
            r_b         <= 6'd0;
            r_fxn       <= 3'd0;
            r_wait      <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 16'd0;
            r_fail_fxn  <= 3'd0;
            r_fail_a    <= 6'd0;
            r_fail_b    <= 6'd0;
            r_fail_out  <= 6'd0;
        end else begin
            case (r_state)
                // DONE behaves like IDLE for one cycle so a start right at
                // run end is not lost.
                StIdle, StDone: begin
                    if (start) begin
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_count <= 16'd0;
                        r_fail_fxn  <= 3'd0;
                        r_fail_a    <= 6'd0;
                        r_fail_b    <= 6'd0;
                        r_fail_out  <= 6'd0;
                        r_fxn       <= 3'd0;
                        r_a         <= w_first_a;
                        r_b         <= w_first_b;
                        r_state     <= StApply;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StApply: begin
                    r_wait  <= SettleLast;
                    r_state <= StWait;
                end
                StWait: begin
                    if (r_wait == 8'd0) begin
                        r_state <= StCheck;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                StCheck: begin
                    if (w_mismatch) begin
                        r_err_count <= w_err_next;
                        // err_count never returns to zero inside a run, so
                        // zero marks the first mismatch.
                        if (r_err_count == 16'd0) begin
                            r_fail_fxn <= r_fxn;
                            r_fail_a   <= r_a;
                            r_fail_b   <= r_b;
                            r_fail_out <= out_i;
                        end
                    end
                    if (w_last_vec) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_count == 16'd0) && !w_mismatch;
                        r_state <= StDone;
                    end else begin
                        r_fxn   <= w_next_fxn;
                        r_a     <= w_next_a;
                        r_b     <= w_next_b;
                        r_state <= StApply;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign a_o       = r_a;
    assign b_o       = r_b;
    assign fxn_o     = r_fxn;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_fxn  = r_fail_fxn;
    assign fail_a    = r_fail_a;
    assign fail_b    = r_fail_b;
    assign fail_out  = r_fail_out;

endmodule

// File: tb/tb_alu_bist_checker.sv
// Testbench for alu_bist_checker (directed build, SETTLE = 2).
// A behavioural model of the logic unit answers the checker, with selectable
// faults. Each run pushes its hand-computed result into a queue; a monitor
// pops and compares when done rises.

module tb_alu_bist_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  a_o;
    logic [5:0]  b_o;
    logic [2:0]  fxn_o;
    logic [5:0]  out_i;
    logic        c_i;
    logic        v_i;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [2:0]  fail_fxn;
    logic [5:0]  fail_a;
    logic [5:0]  fail_b;
    logic [5:0]  fail_out;

    alu_bist_checker #(
        .SETTLE(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_o      (a_o),
        .b_o      (b_o),
        .fxn_o    (fxn_o),
        .out_i    (out_i),
        .c_i      (c_i),
        .v_i      (v_i),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .fail_fxn (fail_fxn),
        .fail_a   (fail_a),
        .fail_b   (fail_b),
        .fail_out (fail_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- unit model with fault injection ----------------
    // 0 none, 1 OUT[0] stuck 0, 2 Cled stuck 1,
    // 3 OUT[0] flipped only at (110,101010,111111),
    // 4 Vled flipped only at (111,101111,111111)
    int fault = 0;

    function automatic logic [7:0] unit_model(input logic [2:0] f, input logic [5:0] a,
                                              input logic [5:0] b);
        int ua, ub, sa, sb, r, sr;
        logic [5:0] o;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 32) ? ua - 64 : ua;
        sb = (ub >= 32) ? ub - 64 : ub;
        o = 6'd0;
        c = 1'b0;
        v = 1'b0;
        case (f)
            3'd0: o = a;
            3'd1: o = b;
            3'd2: begin r = -ua; o = r[5:0]; c = (ua == 0); v = (sa == -32); end
            3'd3: begin r = -ub; o = r[5:0]; c = (ub == 0); v = (sb == -32); end
            3'd4: o = (sa < sb) ? 6'd1 : 6'd0;
            3'd5: o = ~(a ^ b);
            3'd6: begin
                r = ua + ub; o = r[5:0]; c = (r > 63);
                sr = sa + sb; v = (sr > 31) || (sr < -32);
            end
            default: begin
                r = ua + 64 - ub; o = r[5:0]; c = (r > 63);
                sr = sa - sb; v = (sr > 31) || (sr < -32);
            end
        endcase
        return {o, c, v};
    endfunction

    logic [7:0] resp;
    always_comb begin
        resp  = unit_model(fxn_o, a_o, b_o);
        out_i = resp[7:2];
        c_i   = resp[1];
        v_i   = resp[0];
        if (fault == 1) out_i[0] = 1'b0;
        if (fault == 2) c_i = 1'b1;
        if (fault == 3 && fxn_o == 3'b110 && a_o == 6'b101010 && b_o == 6'b111111)
            out_i[0] = ~out_i[0];
        if (fault == 4 && fxn_o == 3'b111 && a_o == 6'b101111 && b_o == 6'b111111)
            v_i = ~v_i;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        pass;
        logic [15:0] err;
        logic [2:0]  ffxn;
        logic [5:0]  fa;
        logic [5:0]  fb;
        logic [5:0]  fout;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   busy_cnt = 0;
    logic done_q = 1'b0;

    function automatic exp_t mk(input logic p, input logic [15:0] e, input logic [2:0] f,
                                input logic [5:0] a, input logic [5:0] b, input logic [5:0] o);
        exp_t x;
        x.pass = p; x.err = e; x.ffxn = f; x.fa = a; x.fb = b; x.fout = o;
        return x;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            done_q   = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done && !done_q) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: actual done=1 required no pending run");
                end else begin
                    mon_e = expq.pop_front();
                    chk("busy_at_done", busy, 1'b0);
                    chk("busy_cycles", busy_cnt, 288);
                    chk("pass", pass, mon_e.pass);
                    chk("err_count", err_count, mon_e.err);
                    chk("fail_fxn", fail_fxn, mon_e.ffxn);
                    chk("fail_a", fail_a, mon_e.fa);
                    chk("fail_b", fail_b, mon_e.fb);
                    chk("fail_out", fail_out, mon_e.fout);
                    chk("last_fxn", fxn_o, 3'b111);
                    chk("last_a", a_o, 6'b101010);
                    chk("last_b", b_o, 6'b111111);
                end
                busy_cnt = 0;
            end
            done_q = done;
        end
    end

    // ---------------- driver ----------------
    task automatic check_all_zero(input string tag);
        chk({tag, "_a_o"}, a_o, 0);
        chk({tag, "_b_o"}, b_o, 0);
        chk({tag, "_fxn_o"}, fxn_o, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_fail_fxn"}, fail_fxn, 0);
        chk({tag, "_fail_a"}, fail_a, 0);
        chk({tag, "_fail_b"}, fail_b, 0);
        chk({tag, "_fail_out"}, fail_out, 0);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // extra_at > 0 issues a second start that many cycles into the run.
    task automatic do_run(input exp_t e, input int extra_at);
        int n;
        expq.push_back(e);
        pulse_start();
        n = 1;
        while (!done && n < 2000) begin
            if (extra_at != 0 && n == extra_at) begin
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: actual done=0 after %0d cycles required done=1", n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;

        fault = 0;
        do_run(mk(1'b1, 16'd0, 3'b000, 6'b000000, 6'b000000, 6'b000000), 0);

        fault = 1;
        do_run(mk(1'b0, 16'd29, 3'b000, 6'b000001, 6'b000001, 6'b000000), 0);

        fault = 2;
        do_run(mk(1'b0, 16'd58, 3'b000, 6'b001100, 6'b000001, 6'b001100), 0);

        fault = 3;
        do_run(mk(1'b0, 16'd1, 3'b110, 6'b101010, 6'b111111, 6'b101000), 0);

        fault = 4;
        do_run(mk(1'b0, 16'd1, 3'b111, 6'b101111, 6'b111111, 6'b110000), 0);

        fault = 0;
        do_run(mk(1'b1, 16'd0, 3'b000, 6'b000000, 6'b000000, 6'b000000), 50);

        // Abort a run with reset at cycle 100, then run to completion.
        fault = 1;
        pulse_start();
        repeat (99) @(posedge clk);
        #1 chk("busy_before_abort", busy, 1'b1);
        rst_n = 1'b0;
        #1 check_all_zero("abort");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        fault = 0;
        do_run(mk(1'b1, 16'd0, 3'b000, 6'b000000, 6'b000000, 6'b000000), 0);

        chk("queue_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_bist_checker.md
# alu_bist_checker

Built-in self-test sequencer for the 6-bit logic unit (`main`). It drives `a`, `b` and `fxn` into the unit, waits a fixed settle time, samples `OUT`, `Cled` and `Vled`, and compares them against an internal golden model. It reports pass/fail, a saturating error count and the first failing vector. It is the response side of the unit's verification loop: it lets the same vector set run on the board with no simulator.

## Interface
Parameters:
- `SETTLE`, default 2: idle cycles between driving a vector and sampling the response, range 1–255.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse; begins a run when idle
- `a_o`  out  6  operand A to the unit
- `b_o`  out  6  operand B to the unit
- `fxn_o`  out  3  function select to the unit
- `out_i`  in  6  unit `OUT`
- `c_i`  in  1  unit `Cled`
- `v_i`  in  1  unit `Vled`
- `busy`  out  1  run in progress
- `done`  out  1  high from run end until next `start`
- `pass`  out  1  valid when `done`; 1 = zero mismatches
- `err_count`  out  16  mismatching vectors, saturates at 65535
- `fail_fxn`  out  3  first failing function
- `fail_a`  out  6  first failing A
- `fail_b`  out  6  first failing B
- `fail_out`  out  6  `out_i` captured at the first failure

## Operation
- Golden model (s = signed 6-bit, sums taken 7 bits wide):
  - 000: OUT = A.
  - 001: OUT = B.
  - 010: OUT = 0 − A, computed as 0 + ~A + 1. C = carry out (1 only if A = 0). V = 1 only if A = 100000.
  - 011: OUT = 0 − B, same rule as 010 applied to B.
  - 100: OUT = {5'b0, s(A) < s(B)}.
  - 101: OUT = ~(A ^ B).
  - 110: OUT = A + B. C = bit 6 of the sum. V = signed overflow.
  - 111: OUT = A + ~B + 1. C = bit 6. V = signed overflow.
  - For fxn 000, 001, 100 and 101, C = V = 0.
- A vector mismatches if any of OUT, C or V differs from the golden model. Each mismatching vector increments `err_count` by 1. The first mismatch of a run loads the `fail_*` registers; later mismatches do not change them.
- Vector order: `fxn` is the outer loop (000→111), the vector index is the inner loop.
- Directed set: 9 (A,B) pairs in this order:
  - (001100,000001)
  - (000000,000000)
  - (000001,000001)
  - (100000,100000)
  - (101010,101010)
  - (101111,101010)
  - (101111,111111)
  - (101000,101010)
  - (101010,111111)
  - This gives 72 vectors per run.
- FSM states and transitions:
  - IDLE: on `start`, clear `err_count`, `fail_*` and `done`; go to APPLY.
  - APPLY: drive the vector for 1 cycle; go to WAIT.
  - WAIT: hold for `SETTLE` cycles; go to CHECK.
  - CHECK: compare and update counters for 1 cycle; go to APPLY for the next vector, or to DONE after the last vector.
  - DONE: set `done` = 1 and `pass` = (`err_count` == 0); go to IDLE.
- `start` while `busy` is ignored. `start` while `done` = 1 begins a new run.
- `a_o`, `b_o` and `fxn_o` hold the current vector from APPLY through CHECK. After a run they hold the last vector until the next `start`.

## Timing
- Reset values:
  - all outputs 0, including `a_o`, `b_o`, `fxn_o`, `busy`, `done`, `pass`, `err_count` and `fail_*`
  - FSM in IDLE
- Reset asserted mid-run aborts the run immediately. No partial results are kept.
- `busy` rises the cycle after `start` is sampled and falls in the same cycle that `done` rises.
- Per-vector cost is `SETTLE` + 2 cycles. A directed run ends `done` 72×(`SETTLE`+2)+1 cycles after `start`.
- Responses are sampled only in CHECK. `out_i`, `c_i` and `v_i` are don't-care in every other state.
- `err_count` saturates: at 65535 further mismatches do not wrap it.

## Configuration
- `ALU_BIST_EXHAUSTIVE_EN`:
  - Defined: the directed set is replaced by a full sweep. Order is fxn outer, A middle, B inner, 000000→111111 each, giving 32768 vectors. A directed run is not available in this build.
  - Undefined: only the 9-pair directed set runs, and the sweep counters are not synthesised.

## Test plan
- Correct model of `main` attached, `SETTLE` = 2, `start` pulse → `busy` for 288 cycles, then `done` = 1, `pass` = 1, `err_count` = 0.
- Golden spot checks at CHECK:
  - fxn 110, A = 101010, B = 111111 → expects OUT = 101001, C = 1, V = 0.
  - fxn 111, A = 101111, B = 111111 → expects OUT = 110000, C = 0, V = 0.
- `out_i[0]` stuck at 0 → `pass` = 0. `fail_fxn` = 000, `fail_a` = 000001, `fail_b` = 000001, `fail_out` = 000000. `err_count` equals the directed vectors whose golden OUT[0] = 1.
- `c_i` stuck at 1 → first failure at vector 0: `fail_fxn` = 000, `fail_a` = 001100, `fail_b` = 000001, `fail_out` = 001100.
- Second `start` pulse at cycle 50 of a run → ignored, run length unchanged. `rst_n` low at cycle 100 → all outputs 0 immediately. A new `start` then completes a full 288-cycle run.
- `ALU_BIST_EXHAUSTIVE_EN` defined, `out_i` stuck at 000000, `SETTLE` = 1 → 32768 vectors, `err_count` saturates at 65535 only if mismatches exceed it. Expect `err_count` < 32768 and `pass` = 0.
